data_sram_bridge: RTL and testbench

- Sits directly downstream of the MEM stage and drives the CPU's data-side SRAM port (en / 4-bit wen / addr / wdata / rdata).
- Converts MEM's word-level request (lsop, address, reg2 store data) into byte-lane write enables and lane-replicated store data.
- Sequences synchronous SRAM reads with a configurable-latency wait FSM and stalls the pipeline until the read word is available.
- Returns the raw 32-bit read word to MEM's load-data input; MEM keeps its existing byte/half extraction.

---
 rtl/data_sram_bridge_pkg.sv | 32 +++
 rtl/data_sram_bridge_lane.sv | 39 +++
 rtl/data_sram_bridge.sv | 140 ++++++++++++++
 tb/tb_data_sram_bridge.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_bridge_pkg.sv
// Shared load/store op encodings and bridge FSM state encoding for the data-side SRAM bridge.
package data_sram_bridge_pkg;

   typedef enum logic [3:0] {
      LSOP_NOP = 4'h0,
      LSOP_LB  = 4'h1,
      LSOP_LBU = 4'h2,
      LSOP_LH  = 4'h3,
      LSOP_LHU = 4'h4,
      LSOP_LW  = 4'h5,
      LSOP_SB  = 4'h6,
      LSOP_SH  = 4'h7,
      LSOP_SW  = 4'h8
   } lsop_e;

   typedef enum logic [1:0] {
      BRIDGE_IDLE = 2'd0,
      RD_WAIT     = 2'd1,
      RD_RESP     = 2'd2
   } bridge_state_e;

   localparam int CNT_W = 3;

   function automatic logic is_load(input logic [3:0] op);
      return op inside {LSOP_LB, LSOP_LBU, LSOP_LH, LSOP_LHU, LSOP_LW};
   endfunction

   function automatic logic is_store(input logic [3:0] op);
      return op inside {LSOP_SB, LSOP_SH, LSOP_SW};
   endfunction

endpackage

// File: rtl/data_sram_bridge_lane.sv
// store_lane_gen: maps lsop + byte offset + LSB-aligned store data to byte write enables,
// lane-replicated write data and a misalignment flag (consumed only under DATA_ALIGN_CHECK_EN).
module store_lane_gen
   import data_sram_bridge_pkg::*;
(
   input  logic [3:0]  lsop,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] data,
   output logic [3:0]  wen,
   output logic [31:0] wdata,
   output logic        misaligned
);

   always_comb begin
      // NOTE: every combinational output is given a default before the case so no path infers a latch.
      wen        = 4'b0000;
      wdata      = data;
      misaligned = 1'b0;
      case (lsop)
         LSOP_SW: begin
            wen        = 4'b1111;
            misaligned = (addr_lo != 2'b00);
         end
         LSOP_SH: begin
            wen        = addr_lo[1] ? 4'b1100 : 4'b0011;
            wdata      = {2{data[15:0]}};
            misaligned = addr_lo[0];
         end
         LSOP_SB: begin
            wen   = 4'b0001 << addr_lo;
            wdata = {4{data[7:0]}};
         end
         LSOP_LW:           misaligned = (addr_lo != 2'b00);
         LSOP_LH, LSOP_LHU: misaligned = addr_lo[0];
         default: ;
      endcase
   end

endmodule

// File: rtl/data_sram_bridge.sv
// Data-side SRAM bridge: issues stores in one cycle, sequences RD_LATENCY-cycle reads with a
// stall FSM. Define DATA_ALIGN_CHECK_EN to block misaligned accesses and raise adel_o/ades_o.
module data_sram_bridge
   import data_sram_bridge_pkg::*;
#(
   parameter int unsigned RD_LATENCY = 1,
   parameter int unsigned ADDR_W     = 32
)(
   input  logic              clk,
   input  logic              resetn,
   input  logic              req_valid_i,
   input  logic              flush_i,
   input  logic [3:0]        lsop_i,
   input  logic [ADDR_W-1:0] memaddr_i,
   input  logic [31:0]       memdata_i,
   output logic              stall_o,
   output logic [31:0]       rdata_o,
   output logic              rdata_valid_o,
   output logic              data_sram_en,
   output logic [3:0]        data_sram_wen,
   output logic [ADDR_W-1:0] data_sram_addr,
   output logic [31:0]       data_sram_wdata,
   input  logic [31:0]       data_sram_rdata,
   output logic              adel_o,
   output logic              ades_o
);

   if (RD_LATENCY < 1 || RD_LATENCY > 7) begin : g_bad_latency
      $error("data_sram_bridge: RD_LATENCY must be within 1..7");
   end

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RD_LATENCY - 1);

   bridge_state_e     state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       rdata_q;
   logic              capture;
   logic              sram_en, stall, rd_valid;
   logic [3:0]        sram_wen;
   logic [3:0]        lane_wen;
   logic [31:0]       lane_wdata;
   logic              misaligned;
   logic              blocked;
   logic              req_ok;

   store_lane_gen u_lane (
      .lsop       (lsop_i),
      .addr_lo    (memaddr_i[1:0]),
      .data       (memdata_i),
      .wen        (lane_wen),
      .wdata      (lane_wdata),
      .misaligned (misaligned)
   );

`ifdef DATA_ALIGN_CHECK_EN
   assign blocked = misaligned;
   assign adel_o  = resetn & req_valid_i & (state_q == BRIDGE_IDLE) & is_load(lsop_i) & misaligned;
   assign ades_o  = resetn & req_valid_i & (state_q == BRIDGE_IDLE) & is_store(lsop_i) & misaligned;
`else
   logic misaligned_unused;
   assign misaligned_unused = misaligned;
   assign blocked = 1'b0;
   assign adel_o  = 1'b0;
   assign ades_o  = 1'b0;
`endif

   // Reset is folded in so a load presented during reset cannot drive the SRAM or stall.
   assign req_ok = resetn & req_valid_i & ~flush_i;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      capture  = 1'b0;
      sram_en  = 1'b0;
      sram_wen = 4'b0000;
      stall    = 1'b0;
      rd_valid = 1'b0;
      unique case (state_q)
         BRIDGE_IDLE: begin
            if (req_ok && !blocked) begin
               if (is_store(lsop_i)) begin
                  sram_en  = 1'b1;
                  sram_wen = lane_wen;
               end else if (is_load(lsop_i)) begin
                  sram_en = 1'b1;
                  stall   = 1'b1;
                  state_d = RD_WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         RD_WAIT: begin
            stall = 1'b1;
            // Last wait cycle is the one where the SRAM word is on data_sram_rdata.
            if (cnt_q == '0) begin
               state_d = RD_RESP;
               capture = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RD_RESP: begin
            rd_valid = 1'b1;
            state_d  = BRIDGE_IDLE;
         end
         default: state_d = BRIDGE_IDLE;
      endcase
      if (flush_i) begin
         state_d  = BRIDGE_IDLE;
         cnt_d    = '0;
         capture  = 1'b0;
         sram_en  = 1'b0;
         sram_wen = 4'b0000;
         stall    = 1'b0;
         rd_valid = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= BRIDGE_IDLE;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (capture) rdata_q <= data_sram_rdata;
      end
   end

   assign data_sram_en    = sram_en;
   assign data_sram_wen   = sram_wen;
   assign data_sram_addr  = sram_en ? {memaddr_i[ADDR_W-1:2], 2'b00} : '0;
   assign data_sram_wdata = (sram_wen != 4'b0000) ? lane_wdata : 32'h0;
   assign stall_o         = stall;
   assign rdata_valid_o   = rd_valid;
   assign rdata_o         = rdata_q;

endmodule

// File: tb/tb_data_sram_bridge.sv
// Directed bench for data_sram_bridge: two instances (RD_LATENCY=1 and 3), each with a
// strict-timing SRAM read model that only presents valid data in the exact latency cycle.
module tb_data_sram_bridge;
   import data_sram_bridge_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rv1, rv3, flush;
   logic [3:0]  lsop;
   logic [31:0] memaddr, memdata;
   logic [31:0] sram_word;

   logic        s1_stall, s1_valid, s1_en, s1_adel, s1_ades;
   logic [3:0]  s1_wen;
   logic [31:0] s1_rdata, s1_addr, s1_wdata, s1_rdata_in;
   logic        s3_stall, s3_valid, s3_en, s3_adel, s3_ades;
   logic [3:0]  s3_wen;
   logic [31:0] s3_rdata, s3_addr, s3_wdata, s3_rdata_in;

   int n_chk = 0;
   int n_err = 0;
   int cyc = 0;
   int issue1 = -100, issue3 = -100;
   int reads1 = 0, reads3 = 0;

   always #5 clk = ~clk;

   data_sram_bridge #(.RD_LATENCY(1), .ADDR_W(32)) dut1 (
      .clk(clk), .resetn(rst_n), .req_valid_i(rv1), .flush_i(flush), .lsop_i(lsop),
      .memaddr_i(memaddr), .memdata_i(memdata), .stall_o(s1_stall), .rdata_o(s1_rdata),
      .rdata_valid_o(s1_valid), .data_sram_en(s1_en), .data_sram_wen(s1_wen),
      .data_sram_addr(s1_addr), .data_sram_wdata(s1_wdata), .data_sram_rdata(s1_rdata_in),
      .adel_o(s1_adel), .ades_o(s1_ades)
   );

   data_sram_bridge #(.RD_LATENCY(3), .ADDR_W(32)) dut3 (
      .clk(clk), .resetn(rst_n), .req_valid_i(rv3), .flush_i(flush), .lsop_i(lsop),
      .memaddr_i(memaddr), .memdata_i(memdata), .stall_o(s3_stall), .rdata_o(s3_rdata),
      .rdata_valid_o(s3_valid), .data_sram_en(s3_en), .data_sram_wen(s3_wen),
      .data_sram_addr(s3_addr), .data_sram_wdata(s3_wdata), .data_sram_rdata(s3_rdata_in),
      .adel_o(s3_adel), .ades_o(s3_ades)
   );

   // SRAM models: read word appears only in the cycle exactly RD_LATENCY after the enable edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (s1_en && s1_wen == 4'b0000) begin issue1 <= cyc; reads1 <= reads1 + 1; end
      if (s3_en && s3_wen == 4'b0000) begin issue3 <= cyc; reads3 <= reads3 + 1; end
   end
   assign s1_rdata_in = (cyc == issue1 + 1) ? sram_word : 32'hBAD0_BAD0;
   assign s3_rdata_in = (cyc == issue3 + 3) ? sram_word : 32'hBAD0_BAD0;

   typedef struct {
      logic        rv;
      logic [3:0]  lsop;
      logic [31:0] addr;
      logic [31:0] data;
      logic        flush;
      logic        exp_en;
      logic [3:0]  exp_wen;
      logic [31:0] exp_wdata;
      logic [31:0] exp_addr;
      logic        exp_stall;
      logic        exp_ades;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs[NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_in(input logic v1, input logic v3, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] d, input logic f);
      rv1 = v1; rv3 = v3; lsop = op; memaddr = a; memdata = d; flush = f;
   endtask

   task automatic adv();
      @(posedge clk);
      #1;
   endtask

   int r0;

   initial begin
      vecs[0]  = '{1'b1, LSOP_SB,  32'h0000_1003, 32'h0000_00A5, 1'b0, 1'b1, 4'b1000, 32'hA5A5_A5A5, 32'h0000_1000, 1'b0, 1'b0};
      vecs[1]  = '{1'b1, LSOP_SB,  32'h0000_1000, 32'h1234_5678, 1'b0, 1'b1, 4'b0001, 32'h7878_7878, 32'h0000_1000, 1'b0, 1'b0};
      vecs[2]  = '{1'b1, LSOP_SB,  32'h0000_1001, 32'h0000_003C, 1'b0, 1'b1, 4'b0010, 32'h3C3C_3C3C, 32'h0000_1000, 1'b0, 1'b0};
      vecs[3]  = '{1'b1, LSOP_SB,  32'h0000_1002, 32'hFFFF_FF81, 1'b0, 1'b1, 4'b0100, 32'h8181_8181, 32'h0000_1000, 1'b0, 1'b0};
      vecs[4]  = '{1'b1, LSOP_SH,  32'h0000_2002, 32'h0000_BEEF, 1'b0, 1'b1, 4'b1100, 32'hBEEF_BEEF, 32'h0000_2000, 1'b0, 1'b0};
      vecs[5]  = '{1'b1, LSOP_SH,  32'h0000_2000, 32'hFFFF_1234, 1'b0, 1'b1, 4'b0011, 32'h1234_1234, 32'h0000_2000, 1'b0, 1'b0};
      vecs[6]  = '{1'b1, LSOP_SW,  32'h0000_2000, 32'hCAFE_F00D, 1'b0, 1'b1, 4'b1111, 32'hCAFE_F00D, 32'h0000_2000, 1'b0, 1'b0};
      vecs[7]  = '{1'b1, LSOP_NOP, 32'h0000_2000, 32'hCAFE_F00D, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0};
      vecs[8]  = '{1'b0, LSOP_SW,  32'h0000_2000, 32'hCAFE_F00D, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0};
      vecs[9]  = '{1'b1, LSOP_SW,  32'h0000_2004, 32'hCAFE_F00D, 1'b1, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b0};
`ifdef DATA_ALIGN_CHECK_EN
      vecs[10] = '{1'b1, LSOP_SH,  32'h0000_4003, 32'h0000_1111, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b1};
      vecs[11] = '{1'b1, LSOP_SW,  32'h0000_4002, 32'h5566_7788, 1'b0, 1'b0, 4'b0000, 32'h0,         32'h0,         1'b0, 1'b1};
`else
      vecs[10] = '{1'b1, LSOP_SH,  32'h0000_4003, 32'h0000_1111, 1'b0, 1'b1, 4'b1100, 32'h1111_1111, 32'h0000_4000, 1'b0, 1'b0};
      vecs[11] = '{1'b1, LSOP_SW,  32'h0000_4002, 32'h5566_7788, 1'b0, 1'b1, 4'b1111, 32'h5566_7788, 32'h0000_4000, 1'b0, 1'b0};
`endif
      vecs[12] = '{1'b1, LSOP_SB,  32'hABCD_EF13, 32'h0000_005A, 1'b0, 1'b1, 4'b1000, 32'h5A5A_5A5A, 32'hABCD_EF10, 1'b0, 1'b0};

      // Reset: a load is presented while resetn is low; nothing may reach the SRAM or stall.
      rst_n = 1'b0;
      sram_word = 32'h0;
      set_in(1'b1, 1'b1, LSOP_LW, 32'h0000_3000, 32'h0, 1'b0);
      #3;
      check("rst.en1",    32'(s1_en),    32'h0);
      check("rst.stall1", 32'(s1_stall), 32'h0);
      check("rst.valid1", 32'(s1_valid), 32'h0);
      check("rst.rdata1", s1_rdata,      32'h0);
      check("rst.addr1",  s1_addr,       32'h0);
      check("rst.en3",    32'(s3_en),    32'h0);
      check("rst.stall3", 32'(s3_stall), 32'h0);
      @(negedge clk);
      set_in(1'b0, 1'b0, LSOP_NOP, 32'h0, 32'h0, 1'b0);
      rst_n = 1'b1;
      adv();

      // Single-cycle store / idle vectors on the latency-1 instance.
      for (int i = 0; i < NV; i++) begin
         set_in(vecs[i].rv, 1'b0, vecs[i].lsop, vecs[i].addr, vecs[i].data, vecs[i].flush);
         @(negedge clk);
         check($sformatf("v%0d.en", i),    32'(s1_en),    32'(vecs[i].exp_en));
         check($sformatf("v%0d.wen", i),   32'(s1_wen),   32'(vecs[i].exp_wen));
         check($sformatf("v%0d.wdata", i), s1_wdata,      vecs[i].exp_wdata);
         check($sformatf("v%0d.addr", i),  s1_addr,       vecs[i].exp_addr);
         check($sformatf("v%0d.stall", i), 32'(s1_stall), 32'(vecs[i].exp_stall));
         check($sformatf("v%0d.valid", i), 32'(s1_valid), 32'h0);
         check($sformatf("v%0d.ades", i),  32'(s1_ades),  32'(vecs[i].exp_ades));
         check($sformatf("v%0d.adel", i),  32'(s1_adel),  32'h0);
         adv();
      end
      set_in(1'b0, 1'b0, LSOP_NOP, 32'h0, 32'h0, 1'b0);
      adv();

      // lw with RD_LATENCY=1, then sb back-to-back.
      r0 = reads1;
      sram_word = 32'hDEAD_BEEF;
      set_in(1'b1, 1'b0, LSOP_LW, 32'h0000_3000, 32'h0, 1'b0);
      @(negedge clk);
      check("lw1.c0.stall", 32'(s1_stall), 32'h1);
      check("lw1.c0.en",    32'(s1_en),    32'h1);
      check("lw1.c0.wen",   32'(s1_wen),   32'h0);
      check("lw1.c0.addr",  s1_addr,       32'h0000_3000);
      check("lw1.c0.adel",  32'(s1_adel),  32'h0);
      adv();
      @(negedge clk);
      check("lw1.c1.stall", 32'(s1_stall), 32'h1);
      check("lw1.c1.en",    32'(s1_en),    32'h0);
      check("lw1.c1.valid", 32'(s1_valid), 32'h0);
      adv();
      @(negedge clk);
      check("lw1.c2.stall", 32'(s1_stall), 32'h0);
      check("lw1.c2.valid", 32'(s1_valid), 32'h1);
      check("lw1.c2.rdata", s1_rdata,      32'hDEAD_BEEF);
      check("lw1.c2.en",    32'(s1_en),    32'h0);
      check("lw1.c2.wen",   32'(s1_wen),   32'h0);
      adv();
      set_in(1'b1, 1'b0, LSOP_SB, 32'h0000_1002, 32'h0000_0077, 1'b0);
      @(negedge clk);
      check("b2b.sb.en",    32'(s1_en),    32'h1);
      check("b2b.sb.wen",   32'(s1_wen),   32'h4);
      check("b2b.sb.wdata", s1_wdata,      32'h7777_7777);
      check("b2b.sb.valid", 32'(s1_valid), 32'h0);
      check("b2b.sb.stall", 32'(s1_stall), 32'h0);
      adv();
      set_in(1'b0, 1'b0, LSOP_NOP, 32'h0, 32'h0, 1'b0);
      check("lw1.reads", 32'(reads1 - r0), 32'h1);
      adv();

      // lw with RD_LATENCY=3: four stall cycles, one valid cycle.
      r0 = reads3;
      sram_word = 32'h1357_2468;
      set_in(1'b0, 1'b1, LSOP_LW, 32'h0000_3004, 32'h0, 1'b0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("lw3.c%0d.stall", c), 32'(s3_stall), 32'h1);
         check($sformatf("lw3.c%0d.valid", c), 32'(s3_valid), 32'h0);
         check($sformatf("lw3.c%0d.en", c),    32'(s3_en),    (c == 0) ? 32'h1 : 32'h0);
         adv();
      end
      @(negedge clk);
      check("lw3.c4.stall", 32'(s3_stall), 32'h0);
      check("lw3.c4.valid", 32'(s3_valid), 32'h1);
      check("lw3.c4.rdata", s3_rdata,      32'h1357_2468);
      adv();
      set_in(1'b0, 1'b0, LSOP_NOP, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      check("lw3.c5.valid", 32'(s3_valid), 32'h0);
      check("lw3.reads",    32'(reads3 - r0), 32'h1);
      adv();

      // Misaligned lw 0x4001.
      sram_word = 32'h0A0B_0C0D;
      set_in(1'b1, 1'b0, LSOP_LW, 32'h0000_4001, 32'h0, 1'b0);
      @(negedge clk);
`ifdef DATA_ALIGN_CHECK_EN
      check("mis.lw.adel",  32'(s1_adel),  32'h1);
      check("mis.lw.en",    32'(s1_en),    32'h0);
      check("mis.lw.stall", 32'(s1_stall), 32'h0);
      adv();
      set_in(1'b0, 1'b0, LSOP_NOP, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      check("mis.lw.novalid", 32'(s1_valid), 32'h0);
      adv();
`else
      check("mis.lw.adel",  32'(s1_adel),  32'h0);
      check("mis.lw.en",    32'(s1_en),    32'h1);
      check("mis.lw.addr",  s1_addr,       32'h0000_4000);
      check("mis.lw.stall", 32'(s1_stall), 32'h1);
      adv();
      adv();
      @(negedge clk);
      check("mis.lw.valid", 32'(s1_valid), 32'h1);
      check("mis.lw.rdata", s1_rdata,      32'h0A0B_0C0D);
      adv();
      set_in(1'b0, 1'b0, LSOP_NOP, 32'h0, 32'h0, 1'b0);
      adv();
`endif

      // Flush during RD_WAIT on the latency-3 instance.
      sram_word = 32'h1111_2222;
      set_in(1'b0, 1'b1, LSOP_LW, 32'h0000_3008, 32'h0, 1'b0);
      @(negedge clk);
      check("fl.c0.stall", 32'(s3_stall), 32'h1);
      adv();
      flush = 1'b1;
      @(negedge clk);
      check("fl.c1.stall", 32'(s3_stall), 32'h0);
      check("fl.c1.en",    32'(s3_en),    32'h0);
      adv();
      set_in(1'b0, 1'b0, LSOP_NOP, 32'h0, 32'h0, 1'b0);
      for (int c = 2; c < 6; c++) begin
         @(negedge clk);
         check($sformatf("fl.c%0d.stall", c), 32'(s3_stall), 32'h0);
         check($sformatf("fl.c%0d.valid", c), 32'(s3_valid), 32'h0);
         adv();
      end

      // Reset asserted mid-load: outputs drop asynchronously, rdata_q cleared.
      set_in(1'b0, 1'b1, LSOP_LW, 32'h0000_300C, 32'h0, 1'b0);
      adv();
      #2;
      rst_n = 1'b0;
      #1;
      check("mrst.stall", 32'(s3_stall), 32'h0);
      check("mrst.en",    32'(s3_en),    32'h0);
      check("mrst.valid", 32'(s3_valid), 32'h0);
      check("mrst.rdata", s3_rdata,      32'h0);
      check("mrst.wen",   32'(s3_wen),   32'h0);
      check("mrst.addr",  s3_addr,       32'h0);
      check("mrst.wdata", s3_wdata,      32'h0);
      check("mrst.flags", 32'({s3_adel, s3_ades}), 32'h0);
      @(negedge clk);
      set_in(1'b0, 1'b0, LSOP_NOP, 32'h0, 32'h0, 1'b0);
      rst_n = 1'b1;
      adv();
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check($sformatf("mrst.p%0d.stall", c), 32'(s3_stall), 32'h0);
         check($sformatf("mrst.p%0d.valid", c), 32'(s3_valid), 32'h0);
         adv();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
